palette_update_scheduler: RTL
=============================

// Module: palette_update_scheduler
// PURPOSE
//  Owns the display palette RAM and schedules host colour updates into it.
//  Host writes are buffered in a small FIFO and committed only while the display is in blanking.
//  This prevents mid-frame colour tearing.
//  The scanline shaper reads the palette every cycle through a registered lookup port.
//  Sits between the host config bus and the Shaper path; replaces a static palette table.
// PARAMETERS
//  INDEX_WIDTH  3   palette index width; ENTRY_COUNT = 2**INDEX_WIDTH entries
//  COLOR_WIDTH  24  packed RGB888 colour, red [23:16], green [15:8], blue [7:0]
//  FIFO_DEPTH   4   pending host writes buffered (power of two, >=2)
// PORTS
//  aClock         in   1            single clock, all logic rising-edge
//  aReset         in   1            asynchronous, active-high reset
//  aWriteValid    in   1            host write request
//  aWriteIndex    in   INDEX_WIDTH  palette entry to update
//  aWriteColor    in   COLOR_WIDTH  new colour for that entry
//  anWriteReady   out  1            FIFO can accept; transfer when valid&&ready
//  aBlanking      in   1            high during horizontal/vertical blanking
//  aLookupIndex   in   INDEX_WIDTH  shaper palette index
//  anOutRed       out  8            lookup result red, 1-cycle latency
//  anOutGreen     out  8            lookup result green
//  anOutBlue      out  8            lookup result blue
//  anPendingCount out  $clog2(FIFO_DEPTH+1)  writes queued, not yet committed
//  anBusy         out  1            high in state COMMIT
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//   - FIFO empty, anPendingCount=0, anWriteReady=1, anBusy=0, state IDLE.
//   - Lookup outputs = 0.
//   - Palette restored: [0]=000000 [1]=ffffff [2]=ff0000 [3]=00ff00 [4]=0000ff, others 000000.
//   - Reset mid-COMMIT discards all queued writes; partially committed entries revert to defaults.
//  Lookup:
//   - Colour registered on every edge from aLookupIndex; never stalled by host traffic.
//   - Same-cycle commit to the looked-up index returns the OLD colour; the new colour is visible next cycle.
//  Host side:
//   - anWriteReady = (count != FIFO_DEPTH), combinational from registered count.
//   - Transfer is accepted on the edge where aWriteValid && anWriteReady; writes to FIFO tail.
//   - A write while full is ignored; the host must hold it until ready.
//  FSM:
//   - IDLE: count==0. Goes to WAIT when count becomes nonzero.
//   - WAIT: count>0 and aBlanking=0. Goes to COMMIT on the first edge with aBlanking=1.
//   - COMMIT: each cycle with aBlanking=1 and count>0, the head entry is written to the palette and popped.
//     One entry per cycle, in FIFO order.
//   - From COMMIT: go to IDLE when the last entry is popped and no push occurs that cycle.
//     Go to WAIT if aBlanking falls; no commit occurs in a cycle where aBlanking=0.
//   - State transitions are evaluated on aBlanking sampled at the edge; there is no partial frame commit lookahead.
//  Counting:
//   - Simultaneous push and pop: count unchanged, both take effect.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - A pop from a full FIFO asserts anWriteReady the next cycle.
//   - Duplicate index writes commit in order; the last one wins.
// TESTING
//  1. Reset -> lookup indices 0..4 give 000000,ffffff,ff0000,00ff00,0000ff one cycle later; index 7 gives 000000.
//  2. Blanking=0, write idx2=123456 -> count=1, state WAIT, lookup idx2 stays ff0000.
//     Raise blanking -> idx2 reads 123456 on the cycle after commit.
//  3. Blanking=0, push 5 writes -> 4 accepted, ready=0 at count=4.
//     Blanking=1 -> 4 commits on 4 consecutive edges, ready=1 after the first pop.
//  4. Queue 3 writes, blanking high for 1 cycle only -> exactly 1 committed, count=2, state WAIT.
//  5. Push and commit in the same edge at count=2 -> count stays 2. Lookup during commit of idx3 returns the old value.
//  6. Assert aReset during COMMIT with 2 pending -> count=0, committed entries read back as defaults.

Source files
------------

// File: rtl/palette_update_scheduler.sv
// Palette RAM with a blanking-gated host update queue.
// Host colour writes are buffered in a small FIFO and drained into the
// palette one entry per cycle, only while the display is blanking.
// The shaper reads the palette through a registered lookup every cycle.
module palette_update_scheduler #(
    parameter int INDEX_WIDTH = 3,
    parameter int COLOR_WIDTH = 24,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             aClock,
    input  logic                             aReset,
    input  logic                             aWriteValid,
    input  logic [INDEX_WIDTH-1:0]           aWriteIndex,
    input  logic [COLOR_WIDTH-1:0]           aWriteColor,
    output logic                             anWriteReady,
    input  logic                             aBlanking,
    input  logic [INDEX_WIDTH-1:0]           aLookupIndex,
    output logic [7:0]                       anOutRed,
    output logic [7:0]                       anOutGreen,
    output logic [7:0]                       anOutBlue,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  anPendingCount,
    output logic                             anBusy
);

    localparam int ENTRY_COUNT = 2 ** INDEX_WIDTH;
    localparam int CW          = $clog2(FIFO_DEPTH + 1);
    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Power-on palette contents: black, white, red, green, blue, then black.
    function automatic logic [COLOR_WIDTH-1:0] default_color(input int idx);
        case (idx)
            1:       return COLOR_WIDTH'(24'hffffff);
            2:       return COLOR_WIDTH'(24'hff0000);
            3:       return COLOR_WIDTH'(24'h00ff00);
            4:       return COLOR_WIDTH'(24'h0000ff);
            default: return '0;
        endcase
    endfunction

    logic [COLOR_WIDTH-1:0] palette_q [ENTRY_COUNT];
    logic [COLOR_WIDTH-1:0] lookup_q;
    logic [INDEX_WIDTH-1:0] fifo_idx_q   [FIFO_DEPTH];
    logic [COLOR_WIDTH-1:0] fifo_color_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    state_t                 state_q, state_d;
    logic                   push, pop;

    // Ready depends only on the registered count, so a pop from a full FIFO
    // opens the input one cycle later.
    assign anWriteReady   = (count_q != FULL_COUNT);
    assign push           = aWriteValid && anWriteReady;
    assign pop            = aBlanking && (count_q != '0);
    assign anPendingCount = count_q;
    assign anBusy         = (state_q == COMMIT);
    assign anOutRed       = lookup_q[23:16];
    assign anOutGreen     = lookup_q[15:8];
    assign anOutBlue      = lookup_q[7:0];

    // Pending-write count: simultaneous push and pop leave it unchanged.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the
        // signal unassigned, which would infer a latch.
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue pointers and count; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge aClock or posedge aReset) begin
        if (aReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before the edge.
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Queue storage; only slots between the pointers are ever read.
    // NOTE: the FIFO storage is deliberately not reset; the pointers and
    // count alone define which entries are valid.
    always_ff @(posedge aClock) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q]   <= aWriteIndex;
            fifo_color_q[wr_ptr_q] <= aWriteColor;
        end
    end

    // Palette: restored to defaults on reset, head entry committed on each pop.
    always_ff @(posedge aClock or posedge aReset) begin
        if (aReset) begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                palette_q[i] <= default_color(i);
            end
        end else if (pop) begin
            palette_q[fifo_idx_q[rd_ptr_q]] <= fifo_color_q[rd_ptr_q];
        end
    end

    // Registered lookup; a same-edge commit is seen one cycle later.
    always_ff @(posedge aClock or posedge aReset) begin
        if (aReset) begin
            lookup_q <= '0;
        end else begin
            lookup_q <= palette_q[aLookupIndex];
        end
    end

    // Scheduler state register.
    always_ff @(posedge aClock or posedge aReset) begin
        if (aReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: idle when the queue drains, otherwise track blanking.
    always_comb begin
        state_d = state_q;
        if (count_d == '0) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:        state_d = WAIT;
                WAIT, COMMIT: state_d = aBlanking ? COMMIT : WAIT;
                default:     state_d = IDLE;
            endcase
        end
    end

endmodule
